// File: rtl/split_vector10_pkg.sv
// Shared widths, bit offsets and state type for the split_vector10 unpacker.
package split_vector10_pkg;

  localparam int FIELD_A_W   = 4;
  localparam int FIELD_B_W   = 6;
  localparam int VEC_W       = 10;
  localparam int FIELD_A_LSB = 0;
  localparam int FIELD_B_LSB = 4;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACCUM    = 1'b1
  } split_state_t;

endpackage

// File: rtl/split_vector10_rise_detect4.sv
// rise_detect4: holds the last accepted 4-bit field and pulses each bit that
// went 0->1 on an accepted word. Both outputs are registered.
module rise_detect4
  import split_vector10_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 en,
  input  logic [FIELD_A_W-1:0] d,
  output logic [FIELD_A_W-1:0] held,
  output logic [FIELD_A_W-1:0] rise
);

  logic [FIELD_A_W-1:0] held_q, held_d;
  logic [FIELD_A_W-1:0] rise_q, rise_d;

  // Next held value and edge pulses; idle cycles clear the pulse.
  always_comb begin
    held_d = held_q;
    rise_d = '0;
    if (en) begin
      held_d = d;
      rise_d = d & ~held_q;
    end
  end

  // Register held field and edge pulses.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      held_q <= '0;
      rise_q <= '0;
    end else begin
      held_q <= held_d;
      rise_q <= rise_d;
    end
  end

  assign held = held_q;
  assign rise = rise_q;

endmodule

// File: rtl/split_vector10.sv
// split_vector10: splits a packed status word into field A / field B, pulses
// rising edges on field A and snapshots a per-frame sticky OR of field B plus
// a saturating count of changed words at every start of frame.
// Optional macro SPLIT_VECTOR10_STICKY_EN enables sticky/count/snapshot logic;
// without it frameB mirrors fieldB, frameChanges is 0 and frameValid rises on
// the first startOfFrame.
//
// state    | meaning
// WAIT_SOF | after reset, no frame boundary seen yet; nothing accumulated
// ACCUM    | inside a frame; accumulating sticky B and change count
module split_vector10
  import split_vector10_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 inValid,
  input  logic [VEC_W-1:0]     inVec,
  output logic [FIELD_A_W-1:0] fieldA,
  output logic [FIELD_B_W-1:0] fieldB,
  output logic [FIELD_A_W-1:0] riseA,
  output logic [FIELD_B_W-1:0] frameB,
  output logic [COUNT_W-1:0]   frameChanges,
  output logic                 frameValid
);

  logic [FIELD_A_W-1:0] new_a;
  logic [FIELD_B_W-1:0] new_b;
  split_state_t         state_q, state_d;
  logic [FIELD_B_W-1:0] field_b_q, field_b_d;
  logic                 frame_valid_q, frame_valid_d;

  assign new_a = inVec[FIELD_A_LSB +: FIELD_A_W];
  assign new_b = inVec[FIELD_B_LSB +: FIELD_B_W];

  rise_detect4 u_rise_a (
    .clk    (clk),
    .resetN (resetN),
    .en     (inValid),
    .d      (new_a),
    .held   (fieldA),
    .rise   (riseA)
  );

`ifdef SPLIT_VECTOR10_STICKY_EN
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [FIELD_B_W-1:0] sticky_q, sticky_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [FIELD_B_W-1:0] frame_b_q, frame_b_d;
  logic [COUNT_W-1:0]   frame_changes_q, frame_changes_d;
  logic                 changed;
  logic [FIELD_B_W-1:0] acc_sticky;
  logic [COUNT_W-1:0]   acc_count;

  // The held word is the registered field pair, so a change is judged against
  // the last accepted word even if it was accepted before the frame opened.
  assign changed = inValid && (inVec != {field_b_q, fieldA});

  // Next-state: the word coinciding with startOfFrame closes the old frame.
  always_comb begin
    state_d         = state_q;
    field_b_d       = inValid ? new_b : field_b_q;
    sticky_d        = sticky_q;
    count_d         = count_q;
    frame_b_d       = frame_b_q;
    frame_changes_d = frame_changes_q;
    frame_valid_d   = frame_valid_q;
    acc_sticky      = sticky_q | (inValid ? new_b : '0);
    acc_count       = (changed && (count_q != COUNT_MAX)) ? count_q + COUNT_W'(1) : count_q;
    case (state_q)
      WAIT_SOF: begin
        sticky_d = '0;
        count_d  = '0;
        if (startOfFrame) state_d = ACCUM;
      end
      ACCUM: begin
        if (startOfFrame) begin
          frame_b_d       = acc_sticky;
          frame_changes_d = acc_count;
          frame_valid_d   = 1'b1;
          sticky_d        = '0;
          count_d         = '0;
        end else begin
          sticky_d = acc_sticky;
          count_d  = acc_count;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  // Single register bank for FSM state, field B and frame snapshot.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q         <= WAIT_SOF;
      field_b_q       <= '0;
      sticky_q        <= '0;
      count_q         <= '0;
      frame_b_q       <= '0;
      frame_changes_q <= '0;
      frame_valid_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      field_b_q       <= field_b_d;
      sticky_q        <= sticky_d;
      count_q         <= count_d;
      frame_b_q       <= frame_b_d;
      frame_changes_q <= frame_changes_d;
      frame_valid_q   <= frame_valid_d;
    end
  end

  assign frameB       = frame_b_q;
  assign frameChanges = frame_changes_q;
`else
  // Next-state without accumulation: frameValid latches on the first boundary.
  always_comb begin
    state_d       = state_q;
    field_b_d     = inValid ? new_b : field_b_q;
    frame_valid_d = frame_valid_q | startOfFrame;
    if (state_q == WAIT_SOF && startOfFrame) state_d = ACCUM;
  end

  // Single register bank for FSM state and field B.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= WAIT_SOF;
      field_b_q     <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      field_b_q     <= field_b_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign frameB       = field_b_q;
  assign frameChanges = '0;
`endif

  assign fieldB     = field_b_q;
  assign frameValid = frame_valid_q;

endmodule
